// File: rtl/zueirai_io_ctrl.sv
// rtl/zueirai_io_ctrl.sv - register-mapped controller for GPIO ports A/B/C
// Direction/output latches, synchronized pin inputs and rising-edge interrupt status.
module zueirai_io_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] addr,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic [7:0] DIR_A,
  output logic [7:0] DIR_B,
  output logic [7:0] DIR_C,
  output logic [7:0] DOUT_A,
  output logic [7:0] DOUT_B,
  output logic [7:0] DOUT_C,
  input  logic [7:0] DIN_A,
  input  logic [7:0] DIN_B,
  input  logic [7:0] DIN_C,
  output logic       irq
);

  logic [7:0] dir_r    [3];
  logic [7:0] out_r    [3];
  logic [7:0] ie_r     [3];
  logic [7:0] stat_r   [3];
  logic [7:0] prev_r   [3];
  logic [7:0] in_v     [3];
  logic [7:0] din_v    [3];
  logic [7:0] stat_nxt [3];
  logic [7:0] sync_r   [3][SYNC_STAGES];
  logic [7:0] rd_mux;
  logic       irq_nxt;

  assign din_v[0] = DIN_A;
  assign din_v[1] = DIN_B;
  assign din_v[2] = DIN_C;

  assign in_v[0] = sync_r[0][SYNC_STAGES-1];
  assign in_v[1] = sync_r[1][SYNC_STAGES-1];
  assign in_v[2] = sync_r[2][SYNC_STAGES-1];

  assign DIR_A  = dir_r[0];
  assign DIR_B  = dir_r[1];
  assign DIR_C  = dir_r[2];
  assign DOUT_A = out_r[0];
  assign DOUT_B = out_r[1];
  assign DOUT_C = out_r[2];

  // OR-ing the new edges after the W1C mask makes a same-cycle set win over clear.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      stat_nxt[p] = (stat_r[p] & ~((wr_en && addr == 4'(12 + p)) ? wdata : 8'h00))
                  | (in_v[p] & ~prev_r[p] & ie_r[p] & ~dir_r[p]);
    end
  end

  always_comb begin
    irq_nxt = 1'b0;
    for (int p = 0; p < 3; p++) begin
      irq_nxt = irq_nxt | (|(stat_r[p] & ie_r[p]));
    end
  end

  // Address 0xF matches nothing and reads back zero.
  always_comb begin
    rd_mux = 8'h00;
    for (int p = 0; p < 3; p++) begin
      if (addr[3:2] == 2'(p)) begin
        case (addr[1:0])
          2'd0:    rd_mux = dir_r[p];
          2'd1:    rd_mux = out_r[p];
          2'd2:    rd_mux = in_v[p];
          default: rd_mux = ie_r[p];
        endcase
      end
      if (addr == 4'(12 + p)) begin
        rd_mux = stat_r[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 3; p++) begin
        dir_r[p]  <= 8'h00;
        out_r[p]  <= 8'h00;
        ie_r[p]   <= 8'h00;
        stat_r[p] <= 8'h00;
        prev_r[p] <= 8'h00;
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_r[p][s] <= 8'h00;
        end
      end
      rdata  <= 8'h00;
      rvalid <= 1'b0;
      irq    <= 1'b0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        sync_r[p][0] <= din_v[p];
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_r[p][s] <= sync_r[p][s-1];
        end
        prev_r[p] <= in_v[p];
        stat_r[p] <= stat_nxt[p];
        if (wr_en && addr[3:2] == 2'(p)) begin
          case (addr[1:0])
            2'd0:    dir_r[p] <= wdata;
            2'd1:    out_r[p] <= wdata;
            2'd3:    ie_r[p]  <= wdata;
            default: ;
          endcase
        end
      end
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= rd_mux;
      end
      irq <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_zueirai_io_ctrl.sv
// tb/tb_zueirai_io_ctrl.sv - directed and randomized checks of zueirai_io_ctrl
// Reference model tracks registers and pin history; pin levels are looked up by delay.
module tb_zueirai_io_ctrl;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid;
  logic [7:0] DIR_A, DIR_B, DIR_C;
  logic [7:0] DOUT_A, DOUT_B, DOUT_C;
  logic [7:0] DIN_A, DIN_B, DIN_C;
  logic       irq;

  always #5 clk = ~clk;

  zueirai_io_ctrl #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .DIR_A(DIR_A), .DIR_B(DIR_B), .DIR_C(DIR_C),
    .DOUT_A(DOUT_A), .DOUT_B(DOUT_B), .DOUT_C(DOUT_C),
    .DIN_A(DIN_A), .DIN_B(DIN_B), .DIN_C(DIN_C),
    .irq(irq)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [23:0] hist [0:8191];
  logic [7:0]  m_dir [3];
  logic [7:0]  m_out [3];
  logic [7:0]  m_ie [3];
  logic [7:0]  m_stat [3];
  logic [7:0]  e_rdata;
  logic        e_rvalid;
  logic        e_irq;

  function automatic logic [23:0] hv(int i);
    if (i < 0) return 24'h0;
    return hist[i];
  endfunction

  function automatic logic [7:0] mread(logic [3:0] a, logic [23:0] inw);
    if (a == 4'hF) return 8'h00;
    if (a >= 4'hC) return m_stat[a - 4'hC];
    case (a[1:0])
      2'd0:    return m_dir[a[3:2]];
      2'd1:    return m_out[a[3:2]];
      2'd2:    return inw[8*a[3:2] +: 8];
      default: return m_ie[a[3:2]];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %02h expected %02h at cycle %0d", tag, obs, exp, cyc);
  endtask

  // One clock: advance the model from the current inputs, clock the DUT, compare outputs.
  task automatic tick();
    logic [23:0] in_now, prv;
    logic [7:0]  set_b, clr_b;
    hist[cyc] = {DIN_C, DIN_B, DIN_A};
    if (rst) begin
      for (int p = 0; p < 3; p++) begin
        m_dir[p] = 8'h00; m_out[p] = 8'h00; m_ie[p] = 8'h00; m_stat[p] = 8'h00;
      end
      e_rdata = 8'h00; e_rvalid = 1'b0; e_irq = 1'b0;
      for (int k = 0; k <= S; k++) if (cyc - k >= 0) hist[cyc - k] = 24'h0;
    end else begin
      in_now = hv(cyc - S);
      prv    = hv(cyc - S - 1);
      e_rvalid = rd_en;
      if (rd_en) e_rdata = mread(addr, in_now);
      e_irq = (|(m_stat[0] & m_ie[0])) || (|(m_stat[1] & m_ie[1])) || (|(m_stat[2] & m_ie[2]));
      for (int p = 0; p < 3; p++) begin
        set_b = in_now[8*p +: 8] & ~prv[8*p +: 8] & m_ie[p] & ~m_dir[p];
        clr_b = (wr_en && addr == 4'(12 + p)) ? wdata : 8'h00;
        m_stat[p] = (m_stat[p] & ~clr_b) | set_b;
      end
      if (wr_en && addr < 4'hC) begin
        case (addr[1:0])
          2'd0:    m_dir[addr[3:2]] = wdata;
          2'd1:    m_out[addr[3:2]] = wdata;
          2'd3:    m_ie[addr[3:2]]  = wdata;
          default: ;
        endcase
      end
    end
    cyc = cyc + 1;
    @(posedge clk);
    #1;
    chk("rvalid", 8'(rvalid), 8'(e_rvalid));
    chk("rdata", rdata, e_rdata);
    chk("irq", 8'(irq), 8'(e_irq));
    chk("dir_a", DIR_A, m_dir[0]);
    chk("dir_b", DIR_B, m_dir[1]);
    chk("dir_c", DIR_C, m_dir[2]);
    chk("dout_a", DOUT_A, m_out[0]);
    chk("dout_b", DOUT_B, m_out[1]);
    chk("dout_c", DOUT_C, m_out[2]);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1; addr = 4'h0; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
    DIN_A = 8'h00; DIN_B = 8'h00; DIN_C = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk("reset_read", rdata, 8'h00);
    end
    chk("reset_irq", 8'(irq), 8'h00);

    wr(4'h4, 8'hF0);
    wr(4'h5, 8'hA5);
    chk("cfg_dir_b", DIR_B, 8'hF0);
    chk("cfg_dout_b", DOUT_B, 8'hA5);
    rd(4'h5);
    chk("cfg_rd_out_b", rdata, 8'hA5);
    chk("cfg_rvalid_hi", 8'(rvalid), 8'h01);
    tick();
    chk("cfg_rvalid_lo", 8'(rvalid), 8'h00);
    chk("cfg_rdata_hold", rdata, 8'hA5);

    DIN_C = 8'h3C;
    rd(4'hA);
    chk("sync_t0", rdata, 8'h00);
    rd(4'hA);
    chk("sync_t1", rdata, 8'h00);
    rd(4'hA);
    chk("sync_t2", rdata, 8'h3C);

    wr(4'h3, 8'h01);
    DIN_A = 8'h01;
    repeat (4) tick();
    chk("int_irq_set", 8'(irq), 8'h01);
    rd(4'hC);
    chk("int_stat_set", rdata, 8'h01);
    wr(4'hC, 8'h01);
    tick();
    chk("int_irq_clr", 8'(irq), 8'h00);
    rd(4'hC);
    chk("int_stat_clr", rdata, 8'h00);
    DIN_A = 8'h03;
    repeat (5) tick();
    chk("int_masked_irq", 8'(irq), 8'h00);

    DIN_A = 8'h00;
    repeat (4) tick();
    DIN_A = 8'h01;
    tick();
    tick();
    wr(4'hC, 8'h01);
    rd(4'hC);
    chk("collision", rdata, 8'h01);

    wr(4'h4, 8'h0F);
    addr = 4'h4; wdata = 8'h55; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_same_old", rdata, 8'h0F);
    rd(4'h4);
    chk("rw_same_new", rdata, 8'h55);

    wr(4'hC, 8'hFF);
    wr(4'h0, 8'h04);
    wr(4'h3, 8'h05);
    DIN_A = 8'h05;
    repeat (4) tick();
    wr(4'h0, 8'h00);
    repeat (4) tick();
    rd(4'hC);
    chk("dir_switch", rdata, 8'h00);

    addr = 4'h5; rd_en = 1'b1; rst = 1'b1;
    tick();
    rd_en = 1'b0; rst = 1'b0;
    chk("rst_drops_read", 8'(rvalid), 8'h00);

    repeat (600) begin
      wr_en = 1'b0; rd_en = 1'b0;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) {DIN_C, DIN_B, DIN_A} = 24'($urandom);
      r = $urandom_range(0, 9);
      addr = 4'($urandom_range(0, 15));
      wdata = 8'($urandom);
      wr_en = (r < 4);
      rd_en = (r >= 3 && r < 7);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
